imem_arbiter: RTL

//   Shares the single-ported combinational instruction ROM between two requesters:

---
 rtl/imem_arbiter_if.sv | 40 ++++
 rtl/imem_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - IF/LS request-response and ROM signals of imem_arbiter
interface imem_arbiter_if;
   logic        if_req_valid;
   logic        if_req_ready;
   logic [63:0] if_req_addr;
   logic        if_flush;
   logic        if_resp_valid;
   logic        if_resp_ready;
   logic [31:0] if_resp_inst;
   logic        if_resp_err;

   logic        ls_req_valid;
   logic        ls_req_ready;
   logic [63:0] ls_req_addr;
   logic        ls_resp_valid;
   logic        ls_resp_ready;
   logic [63:0] ls_resp_data;
   logic        ls_resp_err;

   logic [63:0] rom_addr_o;
   logic [63:0] rom_data_i;

   modport slave (
      input  if_req_valid, if_req_addr, if_flush, if_resp_ready,
      input  ls_req_valid, ls_req_addr, ls_resp_ready,
      input  rom_data_i,
      output if_req_ready, if_resp_valid, if_resp_inst, if_resp_err,
      output ls_req_ready, ls_resp_valid, ls_resp_data, ls_resp_err,
      output rom_addr_o
   );

   modport master (
      output if_req_valid, if_req_addr, if_flush, if_resp_ready,
      output ls_req_valid, ls_req_addr, ls_resp_ready,
      output rom_data_i,
      input  if_req_ready, if_resp_valid, if_resp_inst, if_resp_err,
      input  ls_req_ready, ls_resp_valid, ls_resp_data, ls_resp_err,
      input  rom_addr_o
   );
endinterface

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - round-robin IF/LS arbiter for the shared instruction ROM
// Optional grant/conflict counters when IMEM_ARB_PERF_EN is defined.
module imem_arbiter #(
   parameter logic [63:0] ROM_BASE  = 64'h8000_0000,
   parameter int unsigned ROM_BYTES = 16384
) (
   input  logic          clk,
   input  logic          rst,
`ifdef IMEM_ARB_PERF_EN
   output logic [31:0]   perf_if_grants,
   output logic [31:0]   perf_ls_grants,
   output logic [31:0]   perf_conflicts,
`endif
   imem_arbiter_if.slave bus
);

   typedef enum logic {GRANT_IF = 1'b0, GRANT_LS = 1'b1} grant_e;

   grant_e      last_grant;
   grant_e      last_grant_next;
   logic        if_elig;
   logic        ls_elig;
   logic        grant_if;
   logic        grant_ls;
   logic [63:0] rom_addr;
   logic [63:0] rom_addr_q;
   logic        if_err;
   logic        ls_err;
   logic [31:0] if_inst;

   logic        if_valid_q;
   logic [31:0] if_inst_q;
   logic        if_err_q;
   logic        ls_valid_q;
   logic [63:0] ls_data_q;
   logic        ls_err_q;

   function automatic logic in_range(input logic [63:0] a);
      return (a >= ROM_BASE) && (a < ROM_BASE + 64'(ROM_BYTES));
   endfunction

   // A slot is free when empty or being drained this cycle; flush blocks new fetches.
   always_comb begin
      if_elig  = !rst && !bus.if_flush && bus.if_req_valid &&
                 (!if_valid_q || bus.if_resp_ready);
      ls_elig  = !rst && bus.ls_req_valid && (!ls_valid_q || bus.ls_resp_ready);
      grant_if = if_elig && (!ls_elig || last_grant == GRANT_LS);
      grant_ls = ls_elig && !grant_if;

      last_grant_next = last_grant;
      if (grant_if)
         last_grant_next = GRANT_IF;
      else if (grant_ls)
         last_grant_next = GRANT_LS;

      rom_addr = rom_addr_q;
      if (grant_if)
         rom_addr = bus.if_req_addr;
      else if (grant_ls)
         rom_addr = bus.ls_req_addr;

      if_err  = !in_range(bus.if_req_addr) || (bus.if_req_addr[1:0] != 2'b00);
      ls_err  = !in_range(bus.ls_req_addr);
      if_inst = 32'h0000_0013;
      if (!if_err)
         if_inst = bus.if_req_addr[2] ? bus.rom_data_i[63:32] : bus.rom_data_i[31:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= GRANT_LS;
         rom_addr_q <= 64'h0;
         if_valid_q <= 1'b0;
         if_inst_q  <= 32'h0;
         if_err_q   <= 1'b0;
         ls_valid_q <= 1'b0;
         ls_data_q  <= 64'h0;
         ls_err_q   <= 1'b0;
      end else begin
         last_grant <= last_grant_next;
         rom_addr_q <= rom_addr;

         if (grant_if) begin
            if_valid_q <= 1'b1;
            if_inst_q  <= if_inst;
            if_err_q   <= if_err;
         end else if (bus.if_flush || bus.if_resp_ready) begin
            if_valid_q <= 1'b0;
         end

         if (grant_ls) begin
            ls_valid_q <= 1'b1;
            ls_data_q  <= ls_err ? 64'h0 : bus.rom_data_i;
            ls_err_q   <= ls_err;
         end else if (bus.ls_resp_ready) begin
            ls_valid_q <= 1'b0;
         end
      end
   end

`ifdef IMEM_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_if_grants <= 32'h0;
         perf_ls_grants <= 32'h0;
         perf_conflicts <= 32'h0;
      end else begin
         if (grant_if)
            perf_if_grants <= perf_if_grants + 32'd1;
         if (grant_ls)
            perf_ls_grants <= perf_ls_grants + 32'd1;
         if (if_elig && ls_elig)
            perf_conflicts <= perf_conflicts + 32'd1;
      end
   end
`endif

   assign bus.if_req_ready  = grant_if;
   assign bus.ls_req_ready  = grant_ls;
   assign bus.rom_addr_o    = rom_addr;
   assign bus.if_resp_valid = if_valid_q;
   assign bus.if_resp_inst  = if_inst_q;
   assign bus.if_resp_err   = if_err_q;
   assign bus.ls_resp_valid = ls_valid_q;
   assign bus.ls_resp_data  = ls_data_q;
   assign bus.ls_resp_err   = ls_err_q;

endmodule
